// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store initiator for the data port (port B) of the word-wide memory.
// Byte/half/word requests from the memory stage become word-aligned memory
// transactions. Loads return the addressed lane with sign or zero extension.
// Sub-word stores use a read-modify-write sequence because the memory only
// writes full words.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE, low in reset)
//   req_is_store      1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend loads when 1
//   req_addr          byte address
//   req_wdata         store data (low-order bytes used)
//   resp_valid        one-cycle completion pulse
//   resp_data         extended load data; 0 for stores and errors
//   resp_err          misaligned / illegal size / timeout
//   memOp, addrB, dinB            memory request (all registered)
//   doutB, bValid, NOTready       memory read data, data valid, stall
module lsu_mem_master #(
    parameter logic [1:0] MEM_DISABLE    = 2'b00,
    parameter logic [1:0] MEM_READ_SEXT  = 2'b01,
    parameter logic [1:0] MEM_READ_ZEXT  = 2'b10,
    parameter logic [1:0] MEM_WRITE      = 2'b11,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [1:0]  memOp,
    output logic [31:0] addrB,
    output logic [31:0] dinB,
    input  logic [31:0] doutB,
    input  logic        bValid,
    input  logic        NOTready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

    state_t           state;
    logic             reqIsStore;
    logic             reqUnsigned;
    logic [1:0]       reqSize;
    logic [1:0]       reqLane;
    logic [15:0]      reqWdata;
    logic [CNT_W-1:0] waitCnt;
    logic             badReq;

    // Lane extraction with sign or zero extension (little-endian lanes).
    function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        isUns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return isUns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return isUns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte/half lane of the read word; other lanes kept.
    function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
        logic [31:0] w;
        w = word;
        if (size == 2'b00)
            w[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            w[{lane[1], 4'b0000} +: 16] = wdata;
        return w;
    endfunction

    assign req_ready = (state == IDLE) && !reset;

    assign badReq = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            memOp       <= MEM_DISABLE;
            addrB       <= 32'h0;
            dinB        <= 32'h0;
            resp_valid  <= 1'b0;
            resp_data   <= 32'h0;
            resp_err    <= 1'b0;
            waitCnt     <= '0;
            reqIsStore  <= 1'b0;
            reqUnsigned <= 1'b0;
            reqSize     <= 2'b00;
            reqLane     <= 2'b00;
            reqWdata    <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        reqIsStore  <= req_is_store;
                        reqUnsigned <= req_unsigned;
                        reqSize     <= req_size;
                        reqLane     <= req_addr[1:0];
                        reqWdata    <= req_wdata[15:0];
                        addrB       <= {req_addr[31:2], 2'b00};
                        resp_err    <= 1'b0;
                        resp_data   <= 32'h0;
                        if (badReq) begin
                            // Rejected without touching memory.
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_is_store && req_size == 2'b10) begin
                            dinB  <= req_wdata;
                            memOp <= MEM_WRITE;
                            state <= WR_REQ;
                        end else begin
                            // RMW reads always use the signed read op.
                            memOp <= (!req_is_store && req_unsigned) ?
                                     MEM_READ_ZEXT : MEM_READ_SEXT;
                            state <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!NOTready) begin
                        waitCnt <= '0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Read op stays asserted here; the read is idempotent.
                    if (!NOTready) begin
                        if (bValid) begin
                            if (reqIsStore) begin
                                dinB  <= mergeStore(doutB, reqWdata, reqLane, reqSize);
                                memOp <= MEM_WRITE;
                                state <= WR_REQ;
                            end else begin
                                resp_data  <= extractLoad(doutB, reqLane, reqSize, reqUnsigned);
                                resp_valid <= 1'b1;
                                memOp      <= MEM_DISABLE;
                                state      <= RESP;
                            end
                        end else if (waitCnt == CNT_LAST) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            memOp      <= MEM_DISABLE;
                            state      <= RESP;
                        end else begin
                            waitCnt <= waitCnt + 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (!NOTready) begin
                        resp_valid <= 1'b1;
                        memOp      <= MEM_DISABLE;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    memOp <= MEM_DISABLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  memOp;
    logic [31:0] addrB;
    logic [31:0] dinB;
    logic [31:0] doutB;
    logic        bValid;
    logic        NOTready;

    int errors = 0;
    int checks = 0;

    // Per-request observations filled in by doReq.
    int          lat;
    int          wrCycles;
    logic [31:0] wrDin;
    logic [31:0] wrAddr;
    logic [31:0] rdAddr;
    logic [3:0]  opsSeen;
    logic [31:0] rData;
    logic        rErr;
    int          stallReq;
    logic        holdOff;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    lsu_mem_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .memOp(memOp), .addrB(addrB), .dinB(dinB),
        .doutB(doutB), .bValid(bValid), .NOTready(NOTready)
    );

    // Ideal word memory: read data registered one edge after a read op.
    always @(posedge clk) begin
        if (memOp == 2'b11 && !NOTready)
            mem[addrB[7:2]] <= dinB;
        bValid <= (memOp == 2'b01 || memOp == 2'b10) && !NOTready && !holdOff;
        doutB  <= mem[addrB[7:2]];
    end

    // Issue one request and follow it to resp_valid (bounded).
    task automatic doReq(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_is_store = st; req_size = sz;
        req_unsigned = un; req_addr = ad; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; wrCycles = 0; opsSeen = 4'b0; wrDin = 32'h0; wrAddr = 32'h0; rdAddr = 32'h0;
        forever begin
            opsSeen[memOp] = 1'b1;
            if (memOp == 2'b11) begin
                wrCycles++; wrDin = dinB; wrAddr = addrB;
            end
            if (memOp == 2'b01 || memOp == 2'b10) rdAddr = addrB;
            if (resp_valid || lat >= 40) break;
            if (stallReq > 0) begin
                NOTready = 1'b1; stallReq--;
            end else begin
                NOTready = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        NOTready = 1'b0;
        rData = resp_data;
        rErr  = resp_err;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (memOp !== 2'b00 || addrB !== 32'h0 || dinB !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: memOp=%b addrB=%h dinB=%h required 00/0/0", memOp, addrB, dinB);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: v=%b d=%h e=%b required 0/0/0", resp_valid, resp_data, resp_err);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", req_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
    endtask

    task automatic test_word_store;
        doReq(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        checks++;
        if (wrCycles !== 1 || wrAddr !== 32'h40 || wrDin !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_store_write: cycles=%0d addr=%h din=%h required 1/00000040/deadbeef", wrCycles, wrAddr, wrDin);
        end
        checks++;
        if (lat !== 2 || rErr !== 1'b0 || rData !== 32'h0 || opsSeen !== 4'b1001) begin
            errors++;
            $display("FAIL word_store_resp: lat=%0d err=%b data=%h ops=%b required 2/0/0/1001", lat, rErr, rData, opsSeen);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_one_cycle: resp_valid=%b required 0", resp_valid);
        end
    endtask

    task automatic test_loads;
        logic [31:0] addrs [6] = '{32'h41, 32'h41, 32'h42, 32'h40, 32'h43, 32'h40};
        logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        logic        unsv  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [6] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD,
                                   32'h0000BEEF, 32'hFFFFFFDE, 32'hDEADBEEF};
        logic [3:0]  expOps;
        for (int i = 0; i < 6; i++) begin
            doReq(1'b0, sizes[i], unsv[i], addrs[i], 32'h0);
            expOps = unsv[i] ? 4'b0101 : 4'b0011;
            checks++;
            if (rData !== exps[i] || rErr !== 1'b0 || lat !== 3) begin
                errors++;
                $display("FAIL load_%0d: data=%h err=%b lat=%0d required %h/0/3", i, rData, rErr, lat, exps[i]);
            end
            checks++;
            if (opsSeen !== expOps || rdAddr !== 32'h40) begin
                errors++;
                $display("FAIL load_op_%0d: ops=%b addrB=%h required %b/00000040", i, opsSeen, rdAddr, expOps);
            end
        end
    endtask

    task automatic test_rmw_store;
        doReq(1'b1, 2'b01, 1'b0, 32'h42, 32'hABCD1234);
        checks++;
        if (wrCycles !== 1 || wrDin !== 32'h1234BEEF || wrAddr !== 32'h40) begin
            errors++;
            $display("FAIL half_store_write: cycles=%0d din=%h addr=%h required 1/1234beef/00000040", wrCycles, wrDin, wrAddr);
        end
        checks++;
        if (lat !== 4 || rErr !== 1'b0 || opsSeen !== 4'b1011) begin
            errors++;
            $display("FAIL half_store_resp: lat=%0d err=%b ops=%b required 4/0/1011", lat, rErr, opsSeen);
        end
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        checks++;
        if (rData !== 32'h1234BEEF) begin
            errors++;
            $display("FAIL half_store_readback: got %h required 1234beef", rData);
        end
        doReq(1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFFFF77);
        checks++;
        if (wrDin !== 32'h123477EF || lat !== 4) begin
            errors++;
            $display("FAIL byte_store: din=%h lat=%0d required 123477ef/4", wrDin, lat);
        end
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        checks++;
        if (rData !== 32'h123477EF) begin
            errors++;
            $display("FAIL byte_store_readback: got %h required 123477ef", rData);
        end
    endtask

    task automatic test_errors;
        logic        sts [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  szs [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] ads [3] = '{32'h42, 32'h40, 32'h41};
        for (int i = 0; i < 3; i++) begin
            doReq(sts[i], szs[i], 1'b0, ads[i], 32'h55AA55AA);
            checks++;
            if (lat !== 1 || rErr !== 1'b1 || rData !== 32'h0 || opsSeen !== 4'b0001) begin
                errors++;
                $display("FAIL err_%0d: lat=%0d err=%b data=%h ops=%b required 1/1/0/0001", i, lat, rErr, rData, opsSeen);
            end
            @(posedge clk); #1;
            checks++;
            if (memOp !== 2'b00 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL err_after_%0d: memOp=%b resp_valid=%b required 00/0", i, memOp, resp_valid);
            end
        end
    endtask

    task automatic test_timeout_stall;
        holdOff = 1'b1;
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        holdOff = 1'b0;
        checks++;
        if (lat !== 6 || rErr !== 1'b1 || rData !== 32'h0) begin
            errors++;
            $display("FAIL timeout: lat=%0d err=%b data=%h required 6/1/0", lat, rErr, rData);
        end
        stallReq = 3;
        doReq(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
        checks++;
        if (lat !== 6 || rErr !== 1'b0 || rData !== 32'h00000077) begin
            errors++;
            $display("FAIL stall: lat=%0d err=%b data=%h required 6/0/00000077", lat, rErr, rData);
        end
    endtask

    task automatic test_reset_midop;
        int sawResp;
        holdOff = 1'b1;
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        sawResp = int'(resp_valid);
        checks++;
        if (memOp !== 2'b00) begin
            errors++;
            $display("FAIL midop_reset_op: memOp=%b required 00", memOp);
        end
        reset = 1'b0;
        holdOff = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (memOp !== 2'b00 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_after: memOp=%b ready=%b required 00/1", memOp, req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) sawResp++;
            @(posedge clk); #1;
        end
        checks++;
        if (sawResp !== 0) begin
            errors++;
            $display("FAIL midop_no_resp: resp pulses=%0d required 0", sawResp);
        end
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        checks++;
        if (lat !== 3 || rErr !== 1'b0 || rData !== 32'h123477EF) begin
            errors++;
            $display("FAIL midop_next_load: lat=%0d err=%b data=%h required 3/0/123477ef", lat, rErr, rData);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        NOTready = 1'b0; holdOff = 1'b0; stallReq = 0;
        test_reset();
        test_word_store();
        test_loads();
        test_rmw_store();
        test_errors();
        test_timeout_stall();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
